// File: rtl/digimax_fifo.sv
// Multi-channel DigiMax DAC interface: per-channel direct or timer-drained FIFO mode.
// Optional $D418 SID-sample capture is enabled with `define DIGIMAX_SID_EN.
module digimax_fifo_chan #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic          i_ld,
  input  logic [DW-1:0] i_ld_val,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dac,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_unf,
  output logic          o_ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic [DW-1:0] r_dac;
  logic          w_pop_ok, w_push_ok;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop_ok  = i_pop & ~o_empty & ~i_flush;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = i_push & ~i_flush & (~o_full | w_pop_ok);
  assign o_unf     = i_pop & o_empty;
  assign o_ovf     = i_push & ~i_flush & o_full & ~w_pop_ok;
  assign o_dac     = r_dac;

  always_ff @(posedge i_clk)
    if (w_push_ok) r_mem[r_wp] <= i_din;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_dac <= '0;
    end else begin
      if (i_flush) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push_ok) r_wp <= r_wp + AW'(1);
        if (w_pop_ok)  r_rp <= r_rp + AW'(1);
        case ({w_push_ok, w_pop_ok})
          2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
          2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
      if (i_ld)          r_dac <= i_ld_val;
      else if (w_pop_ok) r_dac <= r_mem[r_rp];
    end
  end
endmodule

module digimax_fifo #(
  parameter int          CHANNELS = 4,
  parameter int          DW       = 8,
  parameter int          DEPTH    = 16,
  parameter logic [15:0] BASE     = 16'hDE00
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_wr_n,
  input  logic                   i_rd_n,
  input  logic [15:0]            i_addr,
  input  logic [7:0]             i_data_in,
  output logic [7:0]             o_data_out,
  output logic                   o_data_oe,
  output logic                   o_sid_sample,
  output logic [CHANNELS*DW-1:0] o_dac
);
  logic                r_wr_n, r_run;
  logic [CHANNELS-1:0] r_mode, r_unf, r_ovf;
  logic [15:0]         r_rate, r_cnt;

  logic                          w_strobe, w_win, w_wr, w_flush, w_tick;
  logic [3:0]                    w_off;
  logic [DW-1:0]                 w_wdata;
  logic [7:0]                    w_rdata;
  logic [CHANNELS-1:0]           w_dwr, w_ld, w_empty, w_full, w_unf_set, w_ovf_set;
  logic [CHANNELS-1:0][DW-1:0]   w_ldv, w_dac;

  assign w_strobe = r_wr_n & ~i_wr_n;
  assign w_win    = (i_addr[15:4] == BASE[15:4]);
  assign w_off    = i_addr[3:0];
  assign w_wr     = w_strobe & w_win;
  assign w_wdata  = DW'(i_data_in);
  assign w_flush  = w_wr & (w_off == 4'hB) & i_data_in[1];
  assign w_tick   = r_run & (r_cnt >= r_rate);
  assign o_dac    = w_dac;

`ifdef DIGIMAX_SID_EN
  logic          w_sid_wr, r_sid;
  logic [DW-1:0] w_sid_val;
  assign w_sid_wr     = w_strobe & (i_addr == 16'hD418);
  assign o_sid_sample = r_sid;
  always_comb begin
    w_sid_val          = '0;
    w_sid_val[DW-2 -: 4] = i_data_in[3:0];
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset)       r_sid <= 1'b0;
    else if (w_strobe) r_sid <= w_sid_wr;
`else
  assign o_sid_sample = 1'b0;
`endif

  // Direct loads (bus or SID capture) override any same-cycle tick pop.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_dwr[c] = w_wr & (w_off == 4'(c));
      w_ld[c]  = w_dwr[c] & ~r_mode[c];
      w_ldv[c] = w_wdata;
`ifdef DIGIMAX_SID_EN
      if (w_sid_wr && c == 0) begin w_ld[c] = 1'b1; w_ldv[c] = w_sid_val; end
      if (w_sid_wr && c == 2) begin w_ld[c] = 1'b1; w_ldv[c] = w_dac[0];  end
`endif
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    digimax_fifo_chan #(.DW(DW), .DEPTH(DEPTH)) u_chan (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_dwr[c] & r_mode[c]),
      .i_pop   (w_tick & r_mode[c]),
      .i_flush (w_flush),
      .i_ld    (w_ld[c]),
      .i_ld_val(w_ldv[c]),
      .i_din   (w_wdata),
      .o_dac   (w_dac[c]),
      .o_empty (w_empty[c]),
      .o_full  (w_full[c]),
      .o_unf   (w_unf_set[c]),
      .o_ovf   (w_ovf_set[c])
    );
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_n <= 1'b1;
      r_run  <= 1'b0;
      r_mode <= '0;
      r_rate <= '0;
      r_cnt  <= '0;
      r_unf  <= '0;
      r_ovf  <= '0;
    end else begin
      r_wr_n <= i_wr_n;
      if (!r_run || w_tick) r_cnt <= '0;
      else                  r_cnt <= r_cnt + 16'd1;
      // New flag events outrank a same-cycle clearing write.
      r_unf <= ((w_wr && w_off == 4'hE) ? '0 : r_unf) | w_unf_set;
      r_ovf <= ((w_wr && w_off == 4'hF) ? '0 : r_ovf) | w_ovf_set;
      if (w_wr) begin
        case (w_off)
          4'h8:    r_mode        <= i_data_in[CHANNELS-1:0];
          4'h9:    r_rate[7:0]   <= i_data_in;
          4'hA:    r_rate[15:8]  <= i_data_in;
          4'hB:    r_run         <= i_data_in[0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      4'h8:    w_rdata = 8'(r_mode);
      4'h9:    w_rdata = r_rate[7:0];
      4'hA:    w_rdata = r_rate[15:8];
      4'hB:    w_rdata = {7'd0, r_run};
      4'hC:    w_rdata = 8'(w_empty);
      4'hD:    w_rdata = 8'(w_full);
      4'hE:    w_rdata = 8'(r_unf);
      4'hF:    w_rdata = 8'(r_ovf);
      default: w_rdata = '0;
    endcase
  end

  assign o_data_oe  = ~i_rd_n & w_win & w_off[3];
  assign o_data_out = o_data_oe ? w_rdata : 8'd0;
endmodule

// File: doc/digimax_fifo.md
# digimax_fifo

Parametrised multi-channel digital-sample DAC interface for the C64 cartridge I/O area. It is the buffered successor to the four-register DigiMax latch. Each channel runs either in direct mode, where a CPU write goes straight to the DAC, or in FIFO mode, where writes queue into a per-channel FIFO that a shared programmable sample-rate timer drains. It sits on the CPU bus beside the cartridge/IO decode and drives the audio mixer's DAC inputs.

## Interface
- CHANNELS, 4: number of DAC channels, 1..8.
- DW, 8: DAC sample width, 5..16. Bus writes supply the low 8 bits; upper bits are zero-filled.
- DEPTH, 16: FIFO entries per channel; power of two, 2..256.
- BASE, 16'hDE00: register window base address; window is 16 bytes.
- clk  in  1  system clock.
- reset  in  1  reset; asynchronous, active-high.
- wr_n  in  1  CPU write, active low; level held for several clk.
- rd_n  in  1  CPU read, active low.
- addr  in  16  CPU address.
- data_in  in  8  CPU write data.
- data_out  out  8  read data; 0 when not selected.
- data_oe  out  1  high while rd_n=0 and addr hits a readable register.
- sid_sample  out  1  high after a $D418 sample write (see Configuration).
- dac  out  CHANNELS*DW  channel c occupies bits [c*DW +: DW].

## Operation
- Write strobe: wr_n=0 this cycle and wr_n=1 the previous cycle, with a registered wr_n. Exactly one action happens per bus write, however long wr_n is held.
- Register map, given as offsets from BASE:
  - 0x0..CHANNELS-1 DATA (W). In direct mode, dac_c <= data_in. In FIFO mode, data_in is pushed to fifo_c.
  - 0x8 MODE (R/W). Bit c=1 puts channel c in FIFO mode.
  - 0x9 RATE_LO, 0xA RATE_HI (R/W). 16-bit RATE.
  - 0xB CTRL (W). Bit0 RUN (R/W via read of 0xB). Bit1 FLUSH is self-clearing and reads as 0.
  - 0xC EMPTY (R), bit per channel.
  - 0xD FULL (R), bit per channel.
  - 0xE UNDERRUN (R, sticky). Any write clears all bits.
  - 0xF OVERFLOW (R, sticky). Any write clears all bits.
  - Unused bits read 0. Offsets CHANNELS..7 are ignored.
- Timer: 16-bit counter.
  - RUN=0: counter held at 0, no ticks.
  - RUN=1: counter increments each clk. When counter >= RATE, a tick fires and the counter returns to 0. Tick period is therefore RATE+1 clocks.
  - A RATE write takes effect immediately. If the counter is already above the new RATE, a tick fires on the next cycle.
- Tick: every FIFO-mode channel pops its head into dac_c.
  - An empty FIFO-mode channel holds dac_c and sets UNDERRUN[c].
  - Direct-mode channels ignore ticks.
- Push to a full FIFO: data is dropped and OVERFLOW[c] is set. Exception: a pop in the same cycle frees a slot, so the push is accepted.
- Push and tick in the same cycle on an empty FIFO: the pop underruns and the push is stored. There is no bypass.
- FLUSH: all read/write pointers and counts go to 0. DAC values and sticky flags are unchanged. FLUSH wins over a same-cycle push, which is discarded.
- Mode change: FIFO contents are retained but not popped while the channel is in direct mode.
- Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits wide.

## Timing
- Direct DATA write: dac_c changes at the clk edge that ends the strobe cycle.
- FIFO push: EMPTY[c] clears one cycle after the strobe cycle.
- Tick pop: dac_c updates at the tick edge.
- Reads are combinational from addr and registered state. data_oe = !rd_n & hit.
- Reset values:
  - dac 0, MODE 0 (legacy direct behaviour), RATE 16'd0, RUN 0.
  - FIFOs empty: EMPTY all ones for existing channels, FULL 0.
  - UNDERRUN 0, OVERFLOW 0, sid_sample 0, counter 0, registered wr_n 1.
- Reset asserted mid-operation clears all of the above asynchronously. No partial push survives.

## Configuration
- DIGIMAX_SID_EN defined:
  - A write strobe to 16'hD418 loads dac_0 with data_in[3:0] placed at bits [DW-2:DW-5], all other bits 0, regardless of channel 0's mode. For DW=8 this is {0, d[3:0], 000}.
  - The same strobe copies the old dac_0 into dac_2 when CHANNELS>=3.
  - The same strobe sets sid_sample. Any other write strobe, at any address, clears it.
  - A $D418 write wins over a same-cycle tick pop on channel 0.
- DIGIMAX_SID_EN undefined: $D418 is ignored and sid_sample is constant 0.

## Test plan
- Reset, then write $DE01=8'h5A in direct mode: dac_1=8'h5A the cycle after the strobe; other channels stay 0. Hold wr_n low for 5 clk: exactly one update.
- MODE=8'h01, RATE=16'd3, push 8'h10, 8'h20, 8'h30 to ch0, RUN=1: dac_0 steps 10→20→30 with 4-clk spacing. The 4th tick sets UNDERRUN[0]=1 and dac_0 holds 8'h30.
- DEPTH=16, RUN=0: 17 pushes to ch2 give FULL[2]=1 and OVERFLOW[2]=1. Write 0xF: OVERFLOW reads 0. FLUSH: EMPTY[2]=1.
- FIFO full, with push and tick in the same cycle: count stays 16 and OVERFLOW stays 0.
- DIGIMAX_SID_EN, dac_0=8'h40, write $D418=8'h0F: dac_0=8'h78, dac_2=8'h40, sid_sample=1. Next write to $DE01 clears sid_sample.
- Assert reset mid-stream with FIFOs half full: all dac=0, EMPTY all ones, counter 0 immediately, without waiting for a clk edge.
